// File: rtl/debug_snapshot_streamer_pkg.sv
// Shared definitions for the debug snapshot streamer: FSM encoding, default
// frame header and frame-geometry helpers.
package mips_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  // Header + cycle counter word + n channel words + checksum byte.
  function automatic int frame_len(input int n, input int bpw);
    return 2 + (n + 1) * bpw;
  endfunction

  function automatic int idx_width(input int n, input int bpw);
    return $clog2(frame_len(n, bpw));
  endfunction

endpackage

// File: rtl/debug_snapshot_streamer_if.sv
// Capture/UART handshake bundle. o_tx_start is a one-cycle request; o_tx_data
// holds the byte until the UART answers with a one-cycle i_tx_done pulse.
interface debug_snapshot_streamer_if
  import mips_debug_pkg::*;
#(
  parameter int BITS_SIZE  = 32,
  parameter int N_CHANNELS = 16,
  parameter int SIZE_TRAMA = 8
);
  logic                             i_capture;
  logic [N_CHANNELS*BITS_SIZE-1:0]  i_channels;
  logic                             i_cycle_en;
  logic                             i_tx_done;
  logic                             o_tx_start;
  logic [SIZE_TRAMA-1:0]            o_tx_data;
  logic                             o_busy;
  logic                             o_frame_done;
  logic [BITS_SIZE-1:0]             o_cycle_count;
  state_e                           o_dbg_state;

  modport master (
    output i_capture, i_channels, i_cycle_en, i_tx_done,
    input  o_tx_start, o_tx_data, o_busy, o_frame_done, o_cycle_count, o_dbg_state
  );

  modport slave (
    input  i_capture, i_channels, i_cycle_en, i_tx_done,
    output o_tx_start, o_tx_data, o_busy, o_frame_done, o_cycle_count, o_dbg_state
  );
endinterface

// File: rtl/debug_snapshot_streamer_byte_sel.sv
// Combinational picker of frame byte idx_i: header, counter/channel payload
// bytes in the configured byte order, or the running checksum.
module snapshot_byte_sel
  import mips_debug_pkg::*;
#(
  parameter int                    BITS_SIZE   = 32,
  parameter int                    N_CHANNELS  = 16,
  parameter int                    SIZE_TRAMA  = 8,
  parameter logic [SIZE_TRAMA-1:0] HEADER_BYTE = SIZE_TRAMA'(HEADER_BYTE_DEF),
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter int                    IDX_W       = 4
) (
  input  logic [IDX_W-1:0]                 idx_i,
  input  logic [BITS_SIZE-1:0]             cyc_snap_i,
  input  logic [N_CHANNELS*BITS_SIZE-1:0]  chan_snap_i,
  input  logic [SIZE_TRAMA-1:0]            chk_i,
  output logic [SIZE_TRAMA-1:0]            byte_o
);
  localparam int BPW       = BITS_SIZE / SIZE_TRAMA;
  localparam int FRAME_LEN = frame_len(N_CHANNELS, BPW);
  localparam int PAYLOAD   = (N_CHANNELS + 1) * BPW;

  // Word 0 is the cycle counter, word k+1 is channel k.
  logic [(N_CHANNELS+1)*BITS_SIZE-1:0] words;
  assign words = {chan_snap_i, cyc_snap_i};

  always_comb begin
    byte_o = '0;
    if (idx_i == '0) begin
      byte_o = HEADER_BYTE;
    end else if (idx_i == IDX_W'(FRAME_LEN - 1)) begin
      byte_o = chk_i;
    end else begin
      for (int i = 0; i < PAYLOAD; i++) begin
        if (idx_i == IDX_W'(i + 1)) begin
          byte_o = words[((i / BPW) * BPW + (MSB_FIRST ? (BPW - 1 - (i % BPW)) : (i % BPW)))
                         * SIZE_TRAMA +: SIZE_TRAMA];
        end
      end
    end
  end

endmodule

// File: rtl/debug_snapshot_streamer.sv
// Debug dump engine: snapshots the cycle counter and debug channels on capture
// and streams them to the UART as one header/payload/XOR-checksum frame.
module debug_snapshot_streamer
  import mips_debug_pkg::*;
#(
  parameter int                    BITS_SIZE   = 32,
  parameter int                    N_CHANNELS  = 16,
  parameter int                    SIZE_TRAMA  = 8,
  parameter logic [SIZE_TRAMA-1:0] HEADER_BYTE = SIZE_TRAMA'(HEADER_BYTE_DEF),
  parameter bit                    MSB_FIRST   = 1'b1
) (
  input  logic                      wire_clk_wz,
  input  logic                      i_reset,
  debug_snapshot_streamer_if.slave  bus
);
  localparam int BPW       = BITS_SIZE / SIZE_TRAMA;
  localparam int FRAME_LEN = frame_len(N_CHANNELS, BPW);
  localparam int IDX_W     = idx_width(N_CHANNELS, BPW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [SIZE_TRAMA-1:0]           chk_q, chk_d;
  logic [SIZE_TRAMA-1:0]           sel_byte;
  logic [BITS_SIZE-1:0]            cnt_q;
  logic [BITS_SIZE-1:0]            cyc_snap_q;
  logic [N_CHANNELS*BITS_SIZE-1:0] chan_snap_q;
  logic                            capture_en;
  logic                            busy;

  snapshot_byte_sel #(
    .BITS_SIZE   (BITS_SIZE),
    .N_CHANNELS  (N_CHANNELS),
    .SIZE_TRAMA  (SIZE_TRAMA),
    .HEADER_BYTE (HEADER_BYTE),
    .MSB_FIRST   (MSB_FIRST),
    .IDX_W       (IDX_W)
  ) u_byte_sel (
    .idx_i       (idx_q),
    .cyc_snap_i  (cyc_snap_q),
    .chan_snap_i (chan_snap_q),
    .chk_i       (chk_q),
    .byte_o      (sel_byte)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    capture_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_capture) begin
          capture_en = 1'b1;
          idx_d      = '0;
          chk_d      = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // The checksum byte is sent as-is; folding it in would also corrupt
        // o_tx_data while the UART is still holding it.
        if (idx_q != LAST_IDX) chk_d = chk_q ^ sel_byte;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SEND;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wire_clk_wz) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
    end
  end

  // Shadow regs only load in IDLE, so they hold steady for the whole frame.
  always_ff @(posedge wire_clk_wz) begin
    if (i_reset) begin
      cyc_snap_q  <= '0;
      chan_snap_q <= '0;
    end else if (capture_en) begin
      cyc_snap_q  <= cnt_q;
      chan_snap_q <= bus.i_channels;
    end
  end

  always_ff @(posedge wire_clk_wz) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (bus.i_cycle_en) begin
      cnt_q <= cnt_q + BITS_SIZE'(1);
    end
  end

  assign busy              = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign bus.o_busy        = busy;
  assign bus.o_tx_start    = (state_q == ST_SEND);
  assign bus.o_tx_data     = busy ? sel_byte : '0;
  assign bus.o_frame_done  = (state_q == ST_DONE);
  assign bus.o_cycle_count = cnt_q;
  assign bus.o_dbg_state   = state_q;

endmodule

// File: tb/tb_debug_snapshot_streamer.sv
// Directed bench: two streamers (MSB-first and LSB-first) share stimulus and a
// UART model that acknowledges each byte a few cycles after o_tx_start.
module tb_debug_snapshot_streamer;
  import mips_debug_pkg::*;

  localparam int BITS = 32;
  localparam int NCH  = 2;
  localparam int TR   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 cap   = 1'b0;
  logic                 en    = 1'b0;
  logic                 spur  = 1'b0;
  logic [NCH*BITS-1:0]  chans = '0;

  debug_snapshot_streamer_if #(.BITS_SIZE(BITS), .N_CHANNELS(NCH), .SIZE_TRAMA(TR)) bus_a ();
  debug_snapshot_streamer_if #(.BITS_SIZE(BITS), .N_CHANNELS(NCH), .SIZE_TRAMA(TR)) bus_b ();

  logic       done_a_q = 1'b0;
  logic       done_b_q = 1'b0;
  logic [2:0] pipe_a   = '0;
  logic [2:0] pipe_b   = '0;

  assign bus_a.i_capture  = cap;
  assign bus_a.i_channels = chans;
  assign bus_a.i_cycle_en = en;
  assign bus_a.i_tx_done  = done_a_q | spur;
  assign bus_b.i_capture  = cap;
  assign bus_b.i_channels = chans;
  assign bus_b.i_cycle_en = en;
  assign bus_b.i_tx_done  = done_b_q | spur;

  debug_snapshot_streamer #(.BITS_SIZE(BITS), .N_CHANNELS(NCH), .SIZE_TRAMA(TR),
                            .HEADER_BYTE(8'hA5), .MSB_FIRST(1'b1)) dut_a (
    .wire_clk_wz (clk),
    .i_reset     (rst),
    .bus         (bus_a)
  );

  debug_snapshot_streamer #(.BITS_SIZE(BITS), .N_CHANNELS(NCH), .SIZE_TRAMA(TR),
                            .HEADER_BYTE(8'hA5), .MSB_FIRST(1'b0)) dut_b (
    .wire_clk_wz (clk),
    .i_reset     (rst),
    .bus         (bus_b)
  );

  // scoreboard state
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  logic [7:0] exp_q[$];
  int fd_a  = 0;
  int fd_b  = 0;
  int total = 0;
  int bad   = 0;

  logic [7:0] s1_msb [14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'h11, 8'h22,
                              8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC6};
  logic [7:0] s1_lsb [14] = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33,
                              8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC6};

  // UART model and byte monitor
  always @(negedge clk) begin
    if (rst) begin
      pipe_a = '0;
      pipe_b = '0;
    end else begin
      pipe_a = {pipe_a[1:0], bus_a.o_tx_start};
      pipe_b = {pipe_b[1:0], bus_b.o_tx_start};
    end
    done_a_q = pipe_a[2];
    done_b_q = pipe_b[2];
    if (bus_a.o_tx_start) got_a.push_back(bus_a.o_tx_data);
    if (bus_b.o_tx_start) got_b.push_back(bus_b.o_tx_data);
    if (bus_a.o_frame_done) fd_a++;
    if (bus_b.o_frame_done) fd_b++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void build_frame(input logic [31:0] cyc, input logic [31:0] c0,
                                      input logic [31:0] c1, input bit msb);
    logic [31:0] w [3];
    logic [7:0]  chk;
    logic [7:0]  b;
    w[0] = cyc; w[1] = c0; w[2] = c1;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    chk = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = msb ? w[k][8*(3-j) +: 8] : w[k][8*j +: 8];
        exp_q.push_back(b);
        chk = chk ^ b;
      end
    end
    exp_q.push_back(chk);
  endfunction

  function automatic void load_exp(input logic [7:0] src [14]);
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back(src[i]);
  endfunction

  task automatic cmp_frame(input string tag, input logic [7:0] got[$]);
    check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  task automatic wait_frames(input string tag, input int want_a, input int want_b);
    int n = 0;
    while ((fd_a < want_a || fd_b < want_b) && n < 400) begin
      tick(1);
      n++;
    end
    check({tag, "_frame_timeout"}, 64'(n < 400), 64'd1);
  endtask

  task automatic wait_bytes(input string tag, input int want);
    int n = 0;
    while (got_a.size() < want && n < 200) begin
      tick(1);
      n++;
    end
    check({tag, "_byte_timeout"}, 64'(n < 200), 64'd1);
  endtask

  task automatic pulse_capture(input string tag);
    cap = 1'b1;
    tick(1);
    cap = 1'b0;
    check({tag, "_start_latency"}, 64'(bus_a.o_tx_start), 64'd1);
    check({tag, "_busy"}, 64'(bus_a.o_busy), 64'd1);
    check({tag, "_hdr"}, 64'(bus_a.o_tx_data), 64'hA5);
  endtask

  initial begin
    int base_a;
    int base_b;
    int n;

    // reset state
    tick(3);
    check("rst_tx_start", 64'(bus_a.o_tx_start), 64'd0);
    check("rst_tx_data", 64'(bus_a.o_tx_data), 64'd0);
    check("rst_busy", 64'(bus_a.o_busy), 64'd0);
    check("rst_frame_done", 64'(bus_a.o_frame_done), 64'd0);
    check("rst_count", 64'(bus_a.o_cycle_count), 64'd0);
    check("rst_state", 64'(bus_a.o_dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick(2);

    // 1 + 2: basic frame, both byte orders
    en = 1'b1;
    tick(5);
    en = 1'b0;
    check("s1_count", 64'(bus_a.o_cycle_count), 64'd5);
    chans = {32'hDEADBEEF, 32'h11223344};
    got_a.delete(); got_b.delete();
    base_a = fd_a; base_b = fd_b;
    pulse_capture("s1");
    wait_frames("s1", base_a + 1, base_b + 1);
    tick(2);
    load_exp(s1_msb);
    cmp_frame("s1_msb", got_a);
    load_exp(s1_lsb);
    cmp_frame("s2_lsb", got_b);
    check("s1_done_count", 64'(fd_a - base_a), 64'd1);
    check("s1_idle", 64'(bus_a.o_busy), 64'd0);
    check("s1_idle_data", 64'(bus_a.o_tx_data), 64'd0);

    // 3: capture while busy, channels changing mid-frame
    chans = {32'hCAFEF00D, 32'h01020304};
    got_a.delete(); got_b.delete();
    base_a = fd_a; base_b = fd_b;
    pulse_capture("s3");
    wait_bytes("s3", 6);
    cap = 1'b1;
    chans = {32'h55555555, 32'hAAAAAAAA};
    tick(1);
    cap = 1'b0;
    wait_frames("s3", base_a + 1, base_b + 1);
    tick(60);
    build_frame(32'd5, 32'h01020304, 32'hCAFEF00D, 1'b1);
    cmp_frame("s3_msb", got_a);
    build_frame(32'd5, 32'h01020304, 32'hCAFEF00D, 1'b0);
    cmp_frame("s3_lsb", got_b);
    check("s3_one_frame", 64'(fd_a - base_a), 64'd1);

    // 4: counter wrap with simultaneous capture
    force dut_a.cnt_q = 32'hFFFF_FFFF;
    tick(1);
    release dut_a.cnt_q;
    check("s4_preset", 64'(bus_a.o_cycle_count), 64'hFFFF_FFFF);
    got_a.delete(); got_b.delete();
    base_a = fd_a; base_b = fd_b;
    en = 1'b1;
    cap = 1'b1;
    tick(1);
    en = 1'b0;
    cap = 1'b0;
    check("s4_wrap", 64'(bus_a.o_cycle_count), 64'd0);
    wait_frames("s4", base_a + 1, base_b + 1);
    tick(2);
    build_frame(32'hFFFF_FFFF, 32'h55555555, 32'hAAAAAAAA, 1'b1);
    exp_q[5] = 8'hAA; exp_q[6] = 8'hAA; exp_q[7] = 8'hAA; exp_q[8] = 8'hAA;
    exp_q[9] = 8'h55; exp_q[10] = 8'h55; exp_q[11] = 8'h55; exp_q[12] = 8'h55;
    build_frame(32'hFFFF_FFFF, 32'hAAAAAAAA, 32'h55555555, 1'b1);
    cmp_frame("s4_msb", got_a);

    // 5: reset during WAIT of byte 4
    chans = {32'h0BADF00D, 32'h12345678};
    got_a.delete(); got_b.delete();
    base_a = fd_a;
    pulse_capture("s5");
    wait_bytes("s5", 4);
    n = 0;
    while (bus_a.o_dbg_state != ST_WAIT && n < 10) begin
      tick(1);
      n++;
    end
    check("s5_in_wait", 64'(bus_a.o_dbg_state), 64'(ST_WAIT));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("s5_tx_start", 64'(bus_a.o_tx_start), 64'd0);
    check("s5_tx_data", 64'(bus_a.o_tx_data), 64'd0);
    check("s5_busy", 64'(bus_a.o_busy), 64'd0);
    check("s5_count", 64'(bus_a.o_cycle_count), 64'd0);
    check("s5_state", 64'(bus_a.o_dbg_state), 64'(ST_IDLE));
    tick(40);
    check("s5_no_done", 64'(fd_a - base_a), 64'd0);
    check("s5_no_more_bytes", 64'(got_a.size()), 64'd4);
    got_a.delete(); got_b.delete();
    base_a = fd_a; base_b = fd_b;
    pulse_capture("s5b");
    wait_frames("s5b", base_a + 1, base_b + 1);
    tick(2);
    build_frame(32'd0, 32'h12345678, 32'h0BADF00D, 1'b1);
    cmp_frame("s5b_msb", got_a);
    build_frame(32'd0, 32'h12345678, 32'h0BADF00D, 1'b0);
    cmp_frame("s5b_lsb", got_b);

    // 6: spurious i_tx_done in IDLE and during SEND
    got_a.delete(); got_b.delete();
    spur = 1'b1;
    tick(3);
    check("s6_idle_start", 64'(bus_a.o_tx_start), 64'd0);
    check("s6_idle_state", 64'(bus_a.o_dbg_state), 64'(ST_IDLE));
    spur = 1'b0;
    tick(1);
    base_a = fd_a; base_b = fd_b;
    pulse_capture("s6");
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    check("s6_send_state", 64'(bus_a.o_dbg_state), 64'(ST_WAIT));
    check("s6_send_start", 64'(bus_a.o_tx_start), 64'd0);
    check("s6_send_hold", 64'(bus_a.o_tx_data), 64'hA5);
    wait_frames("s6", base_a + 1, base_b + 1);
    tick(2);
    build_frame(32'd0, 32'h12345678, 32'h0BADF00D, 1'b1);
    cmp_frame("s6_msb", got_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
